// File: rtl/fas_pkg.sv
// Shared types for the fas_serial sequential adder/subtractor.
// FSM state encoding and add/subtract mode constants.
package fas_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fas_state_t;

  localparam logic FAS_ADD = 1'b1;
  localparam logic FAS_SUB = 1'b0;

endpackage

// File: rtl/fas_slice.sv
// Combinational BITS_PER_CYCLE-bit ripple chain of full adder/subtractor cells.
// c is a carry when a_ns=FAS_ADD and a borrow of a-b when a_ns=FAS_SUB.
module fas_slice
  import fas_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [BITS_PER_CYCLE-1:0] a_slice,
  input  logic [BITS_PER_CYCLE-1:0] b_slice,
  input  logic                      c_in,
  input  logic                      a_ns,
  output logic [BITS_PER_CYCLE-1:0] s_slice,
  output logic                      c_out
);

  always_comb begin : chain
    logic c;
    c       = c_in;
    s_slice = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      s_slice[i] = a_slice[i] ^ b_slice[i] ^ c;
      // a_i ~^ a_ns selects a_i for add and ~a_i for subtract
      c = ((a_slice[i] ~^ a_ns) & (b_slice[i] | c)) | (b_slice[i] & c);
    end
    c_out = c;
  end

endmodule

// File: rtl/fas_serial.sv
// Sequential WIDTH-bit adder/subtractor, BITS_PER_CYCLE bits per RUN cycle, start/busy/done handshake.
// Optional signed overflow output enabled by defining FAS_SERIAL_OVF_EN.
//
// state | meaning
// IDLE  | waiting for start, result registers hold last result
// RUN   | one slice per cycle, LSB slice first, carry kept in carry register
// DONE  | one-cycle done pulse; start here is accepted back-to-back
module fas_serial
  import fas_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             a_ns,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(N - 1);

  fas_state_t                state;
  logic [CNT_W-1:0]          cnt;
  logic                      carry;
  logic                      mode;
  logic [WIDTH-1:0]          a_sh;
  logic [WIDTH-1:0]          b_sh;
  logic [WIDTH-1:0]          s_acc;
  logic [BITS_PER_CYCLE-1:0] s_slice;
  logic                      c_next;
  logic [WIDTH-1:0]          s_next;

  fas_slice #(
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_slice (
    .a_slice(a_sh[BITS_PER_CYCLE-1:0]),
    .b_slice(b_sh[BITS_PER_CYCLE-1:0]),
    .c_in   (carry),
    .a_ns   (mode),
    .s_slice(s_slice),
    .c_out  (c_next)
  );

  // New slice enters at the top; after N cycles the sum is fully aligned.
  assign s_next = WIDTH'({s_slice, s_acc} >> BITS_PER_CYCLE);

`ifdef FAS_SERIAL_OVF_EN
  logic ovf_q;
  logic ovf_next;
  logic a_msb;
  logic b_msb;
  logic s_msb;

  // On the last slice the low slice of the shift registers is the MSB slice.
  assign a_msb = a_sh[BITS_PER_CYCLE-1];
  assign b_msb = b_sh[BITS_PER_CYCLE-1];
  assign s_msb = s_slice[BITS_PER_CYCLE-1];

  always_comb begin
    ovf_next = 1'b0;
    if (mode == FAS_ADD) ovf_next = (a_msb == b_msb) && (s_msb != a_msb);
    else                 ovf_next = (a_msb != b_msb) && (s_msb != a_msb);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (state == RUN && cnt == LAST_SLICE) begin
      ovf_q <= ovf_next;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      cout  <= 1'b0;
      cnt   <= '0;
      carry <= 1'b0;
      mode  <= FAS_SUB;
      a_sh  <= '0;
      b_sh  <= '0;
      s_acc <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            mode  <= a_ns;
            cnt   <= '0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> BITS_PER_CYCLE;
          b_sh  <= b_sh >> BITS_PER_CYCLE;
          s_acc <= s_next;
          carry <= c_next;
          if (cnt == LAST_SLICE) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            s     <= s_next;
            cout  <= c_next;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fas_serial.sv
// Self-checking bench for fas_serial: vector table, handshake corner cases and random
// operations against an arithmetic model, on WIDTH=8 with BITS_PER_CYCLE of 1 and 4.
module tb_fas_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start4;
  logic [7:0] a, b;
  logic       cin, a_ns;
  logic       busy, done, cout, ovf;
  logic [7:0] s;
  logic       busy4, done4, cout4, ovf4;
  logic [7:0] s4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fas_serial #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .a_ns(a_ns),
    .busy(busy), .done(done), .s(s), .cout(cout), .ovf(ovf)
  );

  fas_serial #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a), .b(b), .cin(cin), .a_ns(a_ns),
    .busy(busy4), .done(done4), .s(s4), .cout(cout4), .ovf(ovf4)
  );

  typedef struct {
    bit         use4;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       mode;
    logic [7:0] s;
    logic       cout;
    logic       ovf;   // value with the overflow feature built in
  } vec_t;

  vec_t vt[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic ovf_exp(input logic v);
`ifdef FAS_SERIAL_OVF_EN
    return v;
`else
    return 1'b0 & v;
`endif
  endfunction

  // Reference: plain integer arithmetic, unsigned for s/cout and signed range for overflow.
  task automatic model(input logic [7:0] ma, input logic [7:0] mb, input logic mc, input logic mm,
                       output logic [7:0] ms, output logic mco, output logic mov);
    int u, sv, sa, sb;
    sa = $signed(ma);
    sb = $signed(mb);
    if (mm) begin
      u   = int'(ma) + int'(mb) + int'(mc);
      sv  = sa + sb + int'(mc);
      mco = (u > 255);
    end else begin
      u   = int'(ma) - int'(mb) - int'(mc);
      sv  = sa - sb - int'(mc);
      mco = (u < 0);
    end
    ms  = u[7:0];
    mov = (sv > 127) || (sv < -128);
  endtask

  task automatic wait_done(input bit use4, input int budget, output int busy_cnt, output bit got);
    busy_cnt = 0;
    got = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (use4 ? busy4 : busy) busy_cnt++;
      if (use4 ? done4 : done) begin
        got = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic run_op(input bit use4, input logic [7:0] ta, input logic [7:0] tbv,
                        input logic tc, input logic tm, input logic [7:0] es,
                        input logic ec, input logic eo, input string nm);
    int bc;
    bit got;
    int n;
    n = use4 ? 2 : 8;
    a = ta; b = tbv; cin = tc; a_ns = tm;
    if (use4) start4 = 1'b1; else start = 1'b1;
    tick();
    start = 1'b0; start4 = 1'b0;
    // operands changing after acceptance must not matter
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); a_ns = 1'($urandom);
    wait_done(use4, n + 4, bc, got);
    check({nm, "/done_seen"}, 32'(got), 32'd1);
    check({nm, "/busy_cycles"}, 32'(bc), 32'(n));
    check({nm, "/s"}, 32'(use4 ? s4 : s), 32'(es));
    check({nm, "/cout"}, 32'(use4 ? cout4 : cout), 32'(ec));
    check({nm, "/ovf"}, 32'(use4 ? ovf4 : ovf), 32'(eo));
    tick();
    check({nm, "/done_one_cycle"}, 32'(use4 ? done4 : done), 32'd0);
  endtask

  initial begin
    int bc, cnt;
    bit got;
    logic [7:0] ms;
    logic mco, mov;

    vt[0] = '{0, 8'h3C, 8'h15, 1'b0, 1'b1, 8'h51, 1'b0, 1'b0};
    vt[1] = '{0, 8'h7F, 8'h01, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};
    vt[2] = '{0, 8'h10, 8'h20, 1'b0, 1'b0, 8'hF0, 1'b1, 1'b0};
    vt[3] = '{0, 8'h80, 8'h01, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b1};
    vt[4] = '{0, 8'hFF, 8'h01, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
    vt[5] = '{0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
    vt[6] = '{1, 8'hFF, 8'h01, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
    vt[7] = '{1, 8'h7F, 8'h00, 1'b1, 1'b1, 8'h80, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; start4 = 1'b0;
    a = 8'h00; b = 8'h00; cin = 1'b0; a_ns = 1'b1;
    tick(); tick();
    check("reset/busy", 32'(busy), 32'd0);
    check("reset/done", 32'(done), 32'd0);
    check("reset/s", 32'(s), 32'd0);
    check("reset/cout", 32'(cout), 32'd0);
    check("reset/ovf", 32'(ovf), 32'd0);
    check("reset/busy4", 32'(busy4), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++)
      run_op(vt[i].use4, vt[i].a, vt[i].b, vt[i].cin, vt[i].mode, vt[i].s, vt[i].cout,
             ovf_exp(vt[i].ovf), $sformatf("vec%0d", i));

    // start mid-RUN is ignored
    a = 8'h3C; b = 8'h15; cin = 1'b0; a_ns = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    a = 8'hFF; b = 8'hFF; a_ns = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(0, 12, bc, got);
    check("midstart/done_seen", 32'(got), 32'd1);
    check("midstart/s", 32'(s), 32'h51);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done) cnt++;
    end
    check("midstart/extra_done", 32'(cnt), 32'd0);

    // start during the done cycle is accepted
    a = 8'h3C; b = 8'h15; cin = 1'b0; a_ns = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(0, 12, bc, got);
    check("b2b/first_done", 32'(got), 32'd1);
    check("b2b/first_s", 32'(s), 32'h51);
    a = 8'h10; b = 8'h20; cin = 1'b0; a_ns = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b/busy_next", 32'(busy), 32'd1);
    check("b2b/done_low", 32'(done), 32'd0);
    check("b2b/s_held", 32'(s), 32'h51);
    wait_done(0, 12, bc, got);
    check("b2b/second_done", 32'(got), 32'd1);
    check("b2b/busy_cycles", 32'(bc), 32'd8);
    check("b2b/s", 32'(s), 32'hF0);
    check("b2b/cout", 32'(cout), 32'd1);
    check("b2b/ovf", 32'(ovf), 32'd0);
    tick();

    // rst on the 4th RUN cycle aborts
    a = 8'h55; b = 8'h22; cin = 1'b0; a_ns = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort/busy", 32'(busy), 32'd0);
    check("abort/done", 32'(done), 32'd0);
    check("abort/s", 32'(s), 32'd0);
    check("abort/cout", 32'(cout), 32'd0);
    check("abort/ovf", 32'(ovf), 32'd0);
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (done || busy) cnt++;
      tick();
    end
    check("abort/no_activity", 32'(cnt), 32'd0);
    run_op(0, 8'h3C, 8'h15, 1'b0, 1'b1, 8'h51, 1'b0, 1'b0, "abort/fresh");

    // rst and start together: rst wins
    a = 8'h01; b = 8'h01; rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check("rst_start/busy", 32'(busy), 32'd0);
    tick();
    check("rst_start/busy_later", 32'(busy), 32'd0);
    check("rst_start/done", 32'(done), 32'd0);

    // random operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      logic rc, rm;
      bit ru;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom);
      rm = 1'($urandom);
      ru = 1'($urandom);
      model(ra, rb, rc, rm, ms, mco, mov);
      run_op(ru, ra, rb, rc, rm, ms, mco, ovf_exp(mov), $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
